pwm_ramp_output: RTL and testbench
==================================

# pwm_ramp_output

Parametrised successor to the rocker's two-channel output stage. Takes CH packed actuator levels from the controller (channel 0 = frequency, channel 1 = amplitude by default), moves each channel's applied level one step per ramp tick toward its target, and drives one PWM pin per channel with duty proportional to the applied level. Adds two things the fixed-width stage lacks: slew-limited level changes, and a stop input that drives all channels to zero. Sits between the controller and the power-stage pins.

## Interface
- CH, 2, number of output channels
- LEVEL_W, 3, bits per level; requires LEVEL_W <= PWM_W
- PWM_W, 8, PWM counter width; PWM period = 2^PWM_W clk cycles
- RAMP_DIV, 1024, clk cycles per ramp tick; requires RAMP_DIV >= 1
- clk  in  1  system clock; one clock domain, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; latches level_in as the new targets
- stop  in  1  level-sensitive; while high, all targets are forced to 0
- level_in  in  CH*LEVEL_W  packed targets; channel i is bits [i*LEVEL_W +: LEVEL_W]
- pwm_out  out  CH  PWM pins, registered
- level_now  out  CH*LEVEL_W  applied (ramped) level per channel, registered
- settled  out  1  high when every channel's applied level equals its target

## Operation
- Reset: targets, applied levels, duty registers, prescaler and PWM counter = 0; pwm_out = 0, level_now = 0, settled = 1.
- Target update, evaluated each cycle:
  - stop = 1: all targets become 0. stop wins over a simultaneous load.
  - else load = 1: targets become level_in.
  - else: targets hold.
- Prescaler: counts 0..RAMP_DIV-1 and wraps. Ramp tick = (prescaler == RAMP_DIV-1). It runs continuously and is never reset by load or stop.
- On a tick, each channel independently: applied +1 if applied < target, -1 if applied > target, otherwise unchanged. Levels never wrap; saturation follows from moving toward an in-range target.
- A new target during a ramp replaces the old one. The ramp continues from the current applied level with no restart.
- PWM counter: free-running 0..2^PWM_W-1, wraps to 0.
- Duty: duty[i] = applied[i] << (PWM_W-LEVEL_W). It is latched only on the cycle the PWM counter equals 2^PWM_W-1, so duty changes only at period boundaries and pulses never glitch.
- pwm_out[i] (registered) = (pwm_cnt < duty[i]):
  - level 0 gives a constant low.
  - the maximum level gives (2^LEVEL_W-1)·2^(PWM_W-LEVEL_W) high cycles per period (224 of 256 at defaults).
- settled = AND over channels of (applied == target), registered.

## Timing
- load/stop at cycle t: target valid at t+1. settled falls at t+2 if any channel differs.
- First ramp step: on the first tick at or after t+1. A full 0→7 ramp takes 7 ticks, i.e. at most 7·RAMP_DIV + RAMP_DIV cycles.
- The applied level at the PWM wrap cycle is the duty for the next period. pwm_out lags the counter compare by one cycle.
- Reset asserted mid-ramp or mid-period: all state returns to reset values on the next edge and pwm_out is low the following cycle.
- stop held high: targets stay 0 and load is ignored. On release, the targets remain 0 until the next load.

## Configuration
- PWMOUT_RAMP_EN defined: slew-limited ramping as described; the prescaler is instantiated.
- PWMOUT_RAMP_EN undefined: no prescaler. The applied level equals the target one cycle after the target updates (level_now at t+2). settled is therefore high except for a single cycle after a change. Duty is still latched only at the PWM wrap.

## Test plan
Bench parameters: CH=2, LEVEL_W=3, PWM_W=8, RAMP_DIV=4, PWMOUT_RAMP_EN defined unless stated.
- Reset, then 300 idle cycles -> pwm_out = 0, level_now = 0, settled = 1 throughout.
- load with level_in = {3'd5, 3'd2} -> channel 0 steps 0,1,2 and channel 1 steps 0..5, one step per 4 cycles; settled rises after the 5th step. Steady state: channel 0 high 64/256, channel 1 high 160/256 each period.
- Mid-ramp: load 7, then after 3 steps load 1 -> level_now goes 3,2,1 and holds 1. Duty changes only at counter wraps (check no partial-period pulse).
- stop and load (level 6) in the same cycle while at level 4 -> targets 0, ramp 4,3,2,1,0. After stop is released, levels stay 0 until the next load.
- Assert reset at level 5 in mid-period -> next cycle all state is 0 and pwm_out goes low. The ramp restarts from 0 on the next load.
- PWMOUT_RAMP_EN undefined: load 7 at t -> level_now = 7 at t+2, settled low only at t+2. Duty becomes 224 from the next PWM period.

Source files
------------

// File: rtl/pwm_ramp_output.sv
// Multi-channel PWM output stage: slew-limited level ramping, stop override, period-aligned duty.
// Optional feature macro PWMOUT_RAMP_EN: when undefined, applied levels follow targets directly.
module pwm_ramp_output #(
    parameter int CH       = 2,
    parameter int LEVEL_W  = 3,
    parameter int PWM_W    = 8,
    parameter int RAMP_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  stop,
    input  logic [CH*LEVEL_W-1:0] level_in,
    output logic [CH-1:0]         pwm_out,
    output logic [CH*LEVEL_W-1:0] level_now,
    output logic                  settled
);
    localparam int               SHIFT   = PWM_W - LEVEL_W;
    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};

    if (LEVEL_W > PWM_W) begin : g_bad_width
        $error("LEVEL_W must not exceed PWM_W");
    end
    if (RAMP_DIV < 1) begin : g_bad_div
        $error("RAMP_DIV must be at least 1");
    end

    logic [LEVEL_W-1:0] target_q  [CH];
    logic [LEVEL_W-1:0] target_d  [CH];
    logic [LEVEL_W-1:0] applied_q [CH];
    logic [LEVEL_W-1:0] applied_d [CH];
    logic [PWM_W-1:0]   duty_q    [CH];
    logic [PWM_W-1:0]   duty_d    [CH];
    logic [CH-1:0]      pwm_q;
    logic [CH-1:0]      pwm_d;
    logic [CH-1:0]      match;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [PWM_W-1:0]   pwm_cnt_d;
    logic               settled_q;
    logic               settled_d;
    logic               pwm_wrap;

`ifdef PWMOUT_RAMP_EN
    localparam int               PRE_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RAMP_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             ramp_tick;

    // Free-running: load and stop never realign the tick phase.
    assign ramp_tick = (pre_q == PRE_MAX);
    assign pre_d     = ramp_tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`endif

    assign pwm_wrap  = (pwm_cnt_q == CNT_MAX);
    assign pwm_cnt_d = pwm_cnt_q + 1'b1;
    assign settled_d = &match;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        assign target_d[gi] = stop ? '0 :
                              load ? level_in[gi*LEVEL_W +: LEVEL_W] :
                                     target_q[gi];
`ifdef PWMOUT_RAMP_EN
        assign applied_d[gi] = !ramp_tick                     ? applied_q[gi] :
                               (applied_q[gi] < target_q[gi]) ? applied_q[gi] + 1'b1 :
                               (applied_q[gi] > target_q[gi]) ? applied_q[gi] - 1'b1 :
                                                                applied_q[gi];
`else
        assign applied_d[gi] = target_q[gi];
`endif
        // Duty only moves at the period boundary so a pulse is never cut or stretched.
        assign duty_d[gi] = pwm_wrap ? (PWM_W'(applied_q[gi]) << SHIFT) : duty_q[gi];
        assign pwm_d[gi]  = (pwm_cnt_q < duty_q[gi]);
        assign match[gi]  = (applied_q[gi] == target_q[gi]);
        assign level_now[gi*LEVEL_W +: LEVEL_W] = applied_q[gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                target_q[gi]  <= '0;
                applied_q[gi] <= '0;
                duty_q[gi]    <= '0;
            end else begin
                target_q[gi]  <= target_d[gi];
                applied_q[gi] <= applied_d[gi];
                duty_q[gi]    <= duty_d[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            pwm_q     <= '0;
            settled_q <= 1'b1;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
            settled_q <= settled_d;
        end
    end

    assign pwm_out = pwm_q;
    assign settled = settled_q;
endmodule

// File: tb/tb_pwm_ramp_output.sv
// Scoreboard bench for pwm_ramp_output (CH=2, LEVEL_W=3, PWM_W=8, RAMP_DIV=4); adapts to PWMOUT_RAMP_EN.
`timescale 1ns/1ps
module tb_pwm_ramp_output;
    localparam int CH = 2;
    localparam int LW = 3;
    localparam int PW = 8;
    localparam int RD = 4;
`ifdef PWMOUT_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       stop;
    logic [5:0] level_in;
    logic [1:0] pwm_out;
    logic [5:0] level_now;
    logic       settled;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] exp_lvl [$];
    logic [5:0] obs_lvl [$];
    int         obs_cyc [$];
    logic       obs_set [$];

    pwm_ramp_output #(.CH(CH), .LEVEL_W(LW), .PWM_W(PW), .RAMP_DIV(RD)) dut (
        .clk(clk), .reset(reset), .load(load), .stop(stop), .level_in(level_in),
        .pwm_out(pwm_out), .level_now(level_now), .settled(settled)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; load = 1'b0; stop = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Expected sequence of level_now words: one per tick step, or the target at once without ramping.
    task automatic push_ramp(input logic [5:0] from, input logic [5:0] to, input int maxsteps);
        logic [2:0] a [2];
        logic [2:0] t [2];
        int s;
        for (int c = 0; c < 2; c++) begin
            a[c] = from[c*3 +: 3];
            t[c] = to[c*3 +: 3];
        end
        if (!RAMP) begin
            exp_lvl.push_back(to);
        end else begin
            s = 0;
            while ((a[0] != t[0] || a[1] != t[1]) && s < maxsteps) begin
                for (int c = 0; c < 2; c++) begin
                    if (a[c] < t[c]) a[c] = a[c] + 3'd1;
                    else if (a[c] > t[c]) a[c] = a[c] - 3'd1;
                end
                exp_lvl.push_back({a[1], a[0]});
                s++;
            end
        end
    endtask

    // Records level_now changes (with cycle index after the load cycle) and settled every cycle.
    task automatic observe(input int n, input int budget);
        logic [5:0] prev;
        int seen;
        int cyc;
        prev = level_now; seen = 0; cyc = 0;
        obs_lvl.delete(); obs_cyc.delete(); obs_set.delete();
        while (seen < n && cyc < budget) begin
            tick(); cyc++;
            load = 1'b0;
            obs_set.push_back(settled);
            if (level_now !== prev) begin
                obs_lvl.push_back(level_now);
                obs_cyc.push_back(cyc);
                prev = level_now;
                seen++;
            end
        end
        repeat (2) begin
            tick(); cyc++;
            load = 1'b0;
            obs_set.push_back(settled);
        end
    endtask

    task automatic count_high(output int h0, output int h1);
        h0 = 0; h1 = 0;
        repeat (256) begin
            tick();
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; stop = 1'b0; level_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n_cmp++;
            if ({pwm_out, level_now, settled} !== {2'b00, 6'o00, 1'b1}) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: pwm=%b level=%o settled=%b, required pwm=00 level=00 settled=1",
                         i, pwm_out, level_now, settled);
            end
        end
    endtask

    task automatic test_ramp();
        logic [5:0] e;
        logic [5:0] o;
        int k, h0, h1, hi;
        push_ramp(level_now, {3'd5, 3'd2}, 99);
        level_in = {3'd5, 3'd2}; load = 1'b1;
        observe(exp_lvl.size(), 8*RD + 20);
        n_cmp++;
        if (obs_set[0] !== 1'b1) begin n_bad++; $display("FAIL ramp_settled_t1: got %b, required 1", obs_set[0]); end
        n_cmp++;
        if (obs_set[1] !== 1'b0) begin n_bad++; $display("FAIL ramp_settled_t2: got %b, required 0", obs_set[1]); end
        hi = RAMP ? RD + 1 : 2;
        k = (obs_cyc.size() > 0) ? obs_cyc[0] : -1;
        n_cmp++;
        if (k < 2 || k > hi) begin n_bad++; $display("FAIL ramp_first_step: cycle %0d, required 2..%0d", k, hi); end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            n_cmp++;
            if (obs_cyc[i] - obs_cyc[i-1] != RD) begin
                n_bad++;
                $display("FAIL ramp_interval step %0d: %0d cycles, required %0d", i, obs_cyc[i] - obs_cyc[i-1], RD);
            end
        end
        k = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : 1;
        n_cmp++;
        if (obs_set[k-1] !== 1'b0 || obs_set[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_settled_rise: settled %b then %b around last step, required 0 then 1", obs_set[k-1], obs_set[k]);
        end
        while (exp_lvl.size() > 0) begin
            e = exp_lvl.pop_front();
            o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL ramp_step: level_now=%o, required %o", o, e); end
        end
        repeat (520) tick();
        count_high(h0, h1);
        n_cmp++;
        if (h0 != 64) begin n_bad++; $display("FAIL duty_ch0_level2: high %0d/256, required 64", h0); end
        n_cmp++;
        if (h1 != 160) begin n_bad++; $display("FAIL duty_ch1_level5: high %0d/256, required 160", h1); end
    endtask

    task automatic test_full_scale();
        logic [5:0] e;
        logic [5:0] o;
        int h0, h1;
        push_ramp(level_now, {3'd0, 3'd7}, 99);
        level_in = {3'd0, 3'd7}; load = 1'b1;
        observe(exp_lvl.size(), 8*RD + 20);
        while (exp_lvl.size() > 0) begin
            e = exp_lvl.pop_front();
            o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL full_scale_step: level_now=%o, required %o", o, e); end
        end
        repeat (520) tick();
        count_high(h0, h1);
        n_cmp++;
        if (h0 != 224) begin n_bad++; $display("FAIL duty_max: high %0d/256, required 224", h0); end
        n_cmp++;
        if (h1 != 0) begin n_bad++; $display("FAIL duty_zero: high %0d/256, required 0", h1); end
    endtask

    task automatic test_midramp();
        reset_dut();
        fork
            begin : ramp_side
                logic [5:0] e;
                logic [5:0] o;
                push_ramp(level_now, 6'o77, 3);
                level_in = 6'o77; load = 1'b1;
                observe(exp_lvl.size(), 8*RD + 20);
                while (exp_lvl.size() > 0) begin
                    e = exp_lvl.pop_front();
                    o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
                    n_cmp++;
                    if (o !== e) begin n_bad++; $display("FAIL midramp_up: level_now=%o, required %o", o, e); end
                end
                push_ramp(level_now, 6'o11, 99);
                level_in = 6'o11; load = 1'b1;
                observe(exp_lvl.size(), 8*RD + 20);
                while (exp_lvl.size() > 0) begin
                    e = exp_lvl.pop_front();
                    o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
                    n_cmp++;
                    if (o !== e) begin n_bad++; $display("FAIL midramp_retarget: level_now=%o, required %o", o, e); end
                end
                repeat (40) tick();
                n_cmp++;
                if (level_now !== 6'o11) begin n_bad++; $display("FAIL midramp_hold: level_now=%o, required 11", level_now); end
            end
            begin : pulse_side
                int  run   [2];
                bit  armed [2];
                for (int c = 0; c < 2; c++) begin run[c] = 0; armed[c] = 1'b0; end
                for (int i = 0; i < 1100; i++) begin
                    tick();
                    for (int c = 0; c < 2; c++) begin
                        if (pwm_out[c]) begin
                            run[c]++;
                        end else begin
                            if (armed[c] && run[c] > 0) begin
                                n_cmp++;
                                if (run[c] % 32 != 0) begin
                                    n_bad++;
                                    $display("FAIL pulse_whole ch%0d: high run %0d cycles, required a multiple of 32", c, run[c]);
                                end
                            end
                            armed[c] = 1'b1;
                            run[c]   = 0;
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_stop();
        logic [5:0] e;
        logic [5:0] o;
        reset_dut();
        push_ramp(level_now, 6'o44, 99);
        level_in = 6'o44; load = 1'b1;
        observe(exp_lvl.size(), 8*RD + 20);
        exp_lvl.delete();
        n_cmp++;
        if (level_now !== 6'o44) begin n_bad++; $display("FAIL stop_preload: level_now=%o, required 44", level_now); end
        push_ramp(level_now, 6'o00, 99);
        stop = 1'b1; level_in = 6'o66; load = 1'b1;
        observe(exp_lvl.size(), 8*RD + 20);
        while (exp_lvl.size() > 0) begin
            e = exp_lvl.pop_front();
            o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL stop_ramp_down: level_now=%o, required %o", o, e); end
        end
        level_in = 6'o55; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if ({level_now, settled} !== {6'o00, 1'b1}) begin
            n_bad++;
            $display("FAIL stop_ignores_load: level=%o settled=%b, required 00 and 1", level_now, settled);
        end
        stop = 1'b0;
        repeat (30) tick();
        n_cmp++;
        if (level_now !== 6'o00) begin n_bad++; $display("FAIL stop_release_hold: level_now=%o, required 00", level_now); end
        push_ramp(level_now, 6'o21, 99);
        level_in = 6'o21; load = 1'b1;
        observe(exp_lvl.size(), 8*RD + 20);
        while (exp_lvl.size() > 0) begin
            e = exp_lvl.pop_front();
            o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL stop_reload: level_now=%o, required %o", o, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e;
        logic [5:0] o;
        int wait_cyc;
        push_ramp(level_now, 6'o55, 99);
        level_in = 6'o55; load = 1'b1;
        observe(exp_lvl.size(), 8*RD + 20);
        while (exp_lvl.size() > 0) begin
            e = exp_lvl.pop_front();
            o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL resetmid_ramp: level_now=%o, required %o", o, e); end
        end
        wait_cyc = 0;
        while (pwm_out !== 2'b11 && wait_cyc < 600) begin
            tick();
            wait_cyc++;
        end
        n_cmp++;
        if (pwm_out !== 2'b11) begin n_bad++; $display("FAIL resetmid_pulse_wait: pwm=%b after %0d cycles, required 11", pwm_out, wait_cyc); end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({pwm_out, level_now, settled} !== {2'b00, 6'o00, 1'b1}) begin
            n_bad++;
            $display("FAIL resetmid_state: pwm=%b level=%o settled=%b, required 00 00 1", pwm_out, level_now, settled);
        end
        reset = 1'b0;
        tick();
        push_ramp(level_now, 6'o33, 99);
        level_in = 6'o33; load = 1'b1;
        observe(exp_lvl.size(), 8*RD + 20);
        while (exp_lvl.size() > 0) begin
            e = exp_lvl.pop_front();
            o = (obs_lvl.size() > 0) ? obs_lvl.pop_front() : 6'bxxxxxx;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL resetmid_restart: level_now=%o, required %o", o, e); end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; stop = 1'b0; level_in = '0;
        test_reset();
        test_ramp();
        test_full_scale();
        test_midramp();
        test_stop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
